// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan counter with registered sync, data-enable and
// frame-start outputs. The raster advances one pixel per clock on which
// i_pix_stb is high, so a single system clock serves any pixel rate.
//
// Ports:
//   i_clk      system clock (only clock)
//   i_rst      synchronous active-high reset
//   i_pix_stb  pixel strobe; advances the raster by one pixel
//   o_x, o_y   registered horizontal / vertical position
//   o_h_sync   horizontal sync, active level SYNC_POL
//   o_v_sync   vertical sync (whole-line window), active level SYNC_POL
//   o_de       high inside the visible area
//   o_frame    one-clock pulse when the outputs first show (0,0) after a wrap
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_frame
);

  localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic        wrap_q, wrap_d;
  logic [15:0] x_q, y_q;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        frame_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    wrap_d  = 1'b0;
    if (i_pix_stb) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
          wrap_d  = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 16'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 16'd1;
      end
    end
  end

  // Decode from the current counters; the output stage registers these
  // together with the counters so coordinates and syncs never skew.
  always_comb begin
    hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
    de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

  // wrap_q marks the strobe that took the counters to (0,0); it lasts one
  // clock, so o_frame stays a single pulse even if the strobe then stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      wrap_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~SYNC_ON;
      vs_q    <= ~SYNC_ON;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      wrap_q  <= wrap_d;
      x_q     <= h_cnt_q;
      y_q     <= v_cnt_q;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      frame_q <= wrap_q;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_h_sync = hs_q;
  assign o_v_sync = vs_q;
  assign o_de     = de_q;
  assign o_frame  = frame_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates raster scan coordinates and sync/blanking for the display path. It drives the `i_x`, `i_y` and `i_v_sync` inputs of the `gfx` compositor, and its sync/enable outputs go to the video output pins. It runs on the system clock. A pixel strobe input advances the raster, so one clock domain serves both pixel rates and faster system clocks.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: active level of both syncs (0 = active-low)

Ports:
- `i_clk` in 1: system clock; the only clock
- `i_rst` in 1: synchronous, active-high reset
- `i_pix_stb` in 1: pixel strobe; raster advances one pixel on each clock where it is high
- `o_x` out 16: horizontal counter, 0..H_TOTAL-1
- `o_y` out 16: vertical counter, 0..V_TOTAL-1
- `o_h_sync` out 1: horizontal sync, polarity set by `SYNC_POL`
- `o_v_sync` out 1: vertical sync, polarity set by `SYNC_POL`
- `o_de` out 1: data enable; high when x < H_ACTIVE and y < V_ACTIVE
- `o_frame` out 1: one-clock pulse at start of each new frame

## Operation
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter state is `h_cnt` and `v_cnt`. Both are 16-bit unsigned and reset to 0.
- On a clock with `i_pix_stb`=1:
  - if h_cnt = H_TOTAL-1: h_cnt becomes 0, and v_cnt becomes (v_cnt = V_TOTAL-1) ? 0 : v_cnt+1;
  - otherwise h_cnt increments and v_cnt holds.
- When `i_pix_stb`=0, counters and all outputs hold.
- Horizontal sync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- Vertical sync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
  - It is a whole-line window, aligned to h_cnt = 0. It does not follow hsync.
- Inactive sync level is the complement of `SYNC_POL`.
- All outputs are registered. `o_x`/`o_y` equal the counter values that `o_h_sync`/`o_v_sync`/`o_de` are decoded from on the same cycle; the outputs never skew against each other.
- `o_frame` is high for exactly one `i_clk` cycle: the first cycle on which outputs show x=0, y=0 following a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It is not asserted on the first output cycle after reset.
  - It stays a single-clock pulse even when `i_pix_stb` is low for several cycles afterwards.
- Reset at any point (mid-line, mid-sync) is immediate on that clock edge:
  - counters return to 0;
  - outputs take reset values, with no partial-line completion.
- `i_pix_stb` is ignored on a clock where `i_rst` is high.

## Timing
- Output reset values:
  - `o_x`=0, `o_y`=0, `o_de`=0, `o_frame`=0;
  - `o_h_sync`=`o_v_sync`=~SYNC_POL.
- On the first clock after reset deassertion, outputs show counter state (0,0): `o_de`=1, syncs inactive.
- Latency: a counter update caused by a strobe at edge N appears on outputs at edge N+1, a fixed one-clock lag. Downstream `gfx` combinational logic sees stable coordinates for the whole strobe period.
- With `i_pix_stb` tied high:
  - line period is 800 clocks;
  - frame period is 420000 clocks;
  - `o_frame` period is 420000 clocks.
- Arithmetic is unsigned 16-bit. The counters never reach 65535 for any legal parameters, so no overflow handling is required.
- Parameters are elaboration-time constants. Zero porch widths are legal, and sync windows must still decode correctly. Zero active or sync widths are illegal.

## Test plan
- Reset: hold `i_rst` 3 clocks with `i_pix_stb`=1 -> `o_x`=0, `o_y`=0, `o_de`=0, `o_frame`=0, both syncs 1; on the first cycle after release, `o_de`=1.
- Line decode, `i_pix_stb`=1: `o_de` high for `o_x` 0..639 on line 0; `o_h_sync`=0 for `o_x` 656..751 (exactly 96 clocks); `o_x` wraps 799->0 while `o_y` goes 0->1.
- Frame decode: `o_v_sync`=0 for exactly 1600 clocks (y = 490 and 491); `o_de`=0 on all of lines 480..524; `o_frame` pulses once per 420000 clocks, first pulse 420001 clocks after reset release.
- Strobe every 4th clock: every output changes only on the clock after a strobe; line length 3200 clocks; `o_frame` width still 1 clock.
- Strobe held low for 50 clocks at `o_x`=700 (in hsync): all outputs frozen, hsync stays asserted; on resume `o_x` continues 701.
- Reset mid-operation at `o_x`=300, `o_y`=491 (vsync active) -> next cycle all outputs at reset values; raster restarts from (0,0) with no `o_frame` pulse.
